gb_timer_unit: RTL

Parametrised DIV/TIMA/TMA/TAC timer for the pGB core, replacing the opcode-cycle accumulator with a free-running system counter, a programmable timer with modulo reload, and a CPU register port. It sits beside the CPU on the I/O bus at 0xFF04–0xFF07. It raises the 0x50 timer interrupt request on TIMA overflow, with the delayed-reload behaviour of the original hardware.

---
 rtl/gb_timer_pkg.sv | 21 ++
 rtl/gb_timer_unit_if.sv | 22 ++
 rtl/timer_tap_edge.sv | 48 ++++
 rtl/gb_timer_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/gb_timer_pkg.sv
// Shared constants and types for the DIV/TIMA/TMA/TAC timer block.
// Register addresses, TAC field layout and overflow FSM encoding.
package gb_timer_pkg;

  localparam logic [1:0] TIMER_ADDR_DIV  = 2'd0;
  localparam logic [1:0] TIMER_ADDR_TIMA = 2'd1;
  localparam logic [1:0] TIMER_ADDR_TMA  = 2'd2;
  localparam logic [1:0] TIMER_ADDR_TAC  = 2'd3;

  localparam int TAC_WIDTH  = 3;
  localparam int TAC_EN     = 2;
  localparam int TAC_SEL_HI = 1;
  localparam int TAC_SEL_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RELOAD  = 2'd2
  } timer_state_e;

endpackage

// File: rtl/gb_timer_unit_if.sv
// CPU-side register port of the timer: tick enable, write bus, read data and IRQ.
// The CPU/bus drives through master; the timer block sits behind slave.
interface gb_timer_unit_if #(
  parameter int TIMA_WIDTH = 8
);
  logic                  iTick;
  logic [1:0]            iAddr;
  logic                  iWe;
  logic [TIMA_WIDTH-1:0] iData;
  logic [TIMA_WIDTH-1:0] oData;
  logic                  oInterrupt0x50;

  modport master (
    output iTick, iAddr, iWe, iData,
    input  oData, oInterrupt0x50
  );

  modport slave (
    input  iTick, iAddr, iWe, iData,
    output oData, oInterrupt0x50
  );
endinterface

// File: rtl/timer_tap_edge.sv
// Selects the TAC-chosen system counter bit, gates it with the enable and
// flags a falling edge of the result, including edges caused by DIV/TAC writes.
module timer_tap_edge
  import gb_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int TAP0      = 9,
  parameter int TAP1      = 3,
  parameter int TAP2      = 5,
  parameter int TAP3      = 7
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic [TAC_WIDTH-1:0] tac,
  output logic                 oInc
);

  logic tap_bit;
  logic tin;
  logic prev_tin;
  logic unused_cnt;

  // NOTE: default assignment first keeps this combinational block free of inferred latches.
  always_comb begin
    tap_bit = 1'b0;
    case (tac[TAC_SEL_HI:TAC_SEL_LO])
      2'd0: tap_bit = cnt[TAP0];
      2'd1: tap_bit = cnt[TAP1];
      2'd2: tap_bit = cnt[TAP2];
      2'd3: tap_bit = cnt[TAP3];
      default: tap_bit = 1'b0;
    endcase
  end

  assign tin = tac[TAC_EN] & tap_bit;

  // Sampled every clock, not just on ticks, so register writes that drop tin are caught.
  // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge iClock) begin
    if (iReset) prev_tin <= 1'b0;
    else        prev_tin <= tin;
  end

  assign oInc       = prev_tin & ~tin;
  assign unused_cnt = ^cnt;

endmodule

// File: rtl/gb_timer_unit.sv
// DIV/TIMA/TMA/TAC timer: free-running system counter, programmable timer with
// delayed modulo reload, CPU register port and the 0x50 interrupt pulse.
module gb_timer_unit
  import gb_timer_pkg::*;
#(
  parameter int CNT_WIDTH    = 16,
  parameter int TIMA_WIDTH   = 8,
  parameter int TAP0         = 9,
  parameter int TAP1         = 3,
  parameter int TAP2         = 5,
  parameter int TAP3         = 7,
  parameter int RELOAD_DELAY = 4
) (
  input logic            iClock,
  input logic            iReset,
  gb_timer_unit_if.slave bus
);

  // Down-counter holds RELOAD_DELAY-1; RELOAD_DELAY is expected to be at least 2.
  localparam int DLY_W = (RELOAD_DELAY > 2) ? $clog2(RELOAD_DELAY) : 1;

  logic [CNT_WIDTH-1:0]  cnt;
  logic [TIMA_WIDTH-1:0] tima;
  logic [TIMA_WIDTH-1:0] tma;
  logic [TAC_WIDTH-1:0]  tac;
  logic [DLY_W-1:0]      dly;
  timer_state_e          state;
  logic                  irq;
  logic                  inc;
  logic                  div_we, tima_we, tma_we, tac_we;
  logic [TIMA_WIDTH-1:0] tma_next;
  logic [TIMA_WIDTH-1:0] rdata;

  assign div_we  = bus.iWe && (bus.iAddr == TIMER_ADDR_DIV);
  assign tima_we = bus.iWe && (bus.iAddr == TIMER_ADDR_TIMA);
  assign tma_we  = bus.iWe && (bus.iAddr == TIMER_ADDR_TMA);
  assign tac_we  = bus.iWe && (bus.iAddr == TIMER_ADDR_TAC);

  // A TMA write landing in the reload cycle is the value that gets loaded.
  assign tma_next = tma_we ? bus.iData : tma;

  timer_tap_edge #(
    .CNT_WIDTH (CNT_WIDTH),
    .TAP0      (TAP0),
    .TAP1      (TAP1),
    .TAP2      (TAP2),
    .TAP3      (TAP3)
  ) u_tap_edge (
    .iClock (iClock),
    .iReset (iReset),
    .cnt    (cnt),
    .tac    (tac),
    .oInc   (inc)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      cnt <= '0;
      tma <= '0;
      tac <= '0;
    end else begin
      if (div_we)         cnt <= '0;
      else if (bus.iTick) cnt <= cnt + CNT_WIDTH'(1);
      if (tma_we) tma <= bus.iData;
      if (tac_we) tac <= bus.iData[TAC_WIDTH-1:0];
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= ST_IDLE;
      tima  <= '0;
      dly   <= '0;
      irq   <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tima_we) begin
            tima <= bus.iData;
          end else if (inc) begin
            if (&tima) begin
              tima  <= '0;
              dly   <= DLY_W'(RELOAD_DELAY - 1);
              state <= ST_PENDING;
            end else begin
              tima <= tima + TIMA_WIDTH'(1);
            end
          end
        end
        ST_PENDING: begin
          if (tima_we) begin
            tima  <= bus.iData;
            state <= ST_IDLE;
          end else begin
            if (inc) tima <= tima + TIMA_WIDTH'(1);
            if (bus.iTick) begin
              dly <= dly - DLY_W'(1);
              if (dly <= DLY_W'(1)) state <= ST_RELOAD;
            end
          end
        end
        ST_RELOAD: begin
          // TIMA writes and edge increments are dropped while the reload is outstanding.
          if (bus.iTick) begin
            tima  <= tma_next;
            irq   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.iAddr)
      TIMER_ADDR_DIV:  rdata = cnt[CNT_WIDTH-1 -: 8];
      TIMER_ADDR_TIMA: rdata = tima;
      TIMER_ADDR_TMA:  rdata = tma;
      TIMER_ADDR_TAC:  rdata = {{(TIMA_WIDTH-TAC_WIDTH){1'b1}}, tac};
      default:         rdata = '0;
    endcase
  end

  assign bus.oData          = rdata;
  assign bus.oInterrupt0x50 = irq;

endmodule
